// File: rtl/toysram_scan_ctl.sv
// Scan-chain front end for the RA0 macro controls. The pin-driven te/scan_clk/scan_in
// are synchronized into clk; status is captured on te rise and config committed on te fall.
module toysram_scan_ctl #(
  parameter int WIDTH = 128,
  parameter int SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] CFG_RST = '0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          te,
  input  logic                          scan_clk,
  input  logic                          scan_in,
  output logic                          scan_out,
  input  logic [WIDTH-1:0]              cap_data,
  output logic [WIDTH-1:0]              cfg,
  output logic                          cfg_upd,
  output logic                          busy,
  output logic [$clog2(WIDTH+2)-1:0]    bit_cnt,
  output logic                          len_err,
  input  logic                          err_clr
);

  localparam int CW = $clog2(WIDTH+2);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_SAT  = CW'(WIDTH+1);

  logic [SYNC_STAGES-1:0] te_sync, sclk_sync, sin_sync;
  logic                   te_q, sclk_q;
  logic [WIDTH-1:0]       sr;
  logic                   te_s, sclk_s, sin_s;
  logic                   te_rise, te_fall, sclk_rise, commit_ok;

  assign te_s      = te_sync[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign sin_s     = sin_sync[SYNC_STAGES-1];
  assign te_rise   = te_s & ~te_q;
  assign te_fall   = ~te_s & te_q;
  assign sclk_rise = sclk_s & ~sclk_q;
  assign commit_ok = te_fall && (bit_cnt == CNT_FULL);

  assign busy     = te_s;
  assign scan_out = sr[WIDTH-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      te_sync   <= '0;
      sclk_sync <= '0;
      sin_sync  <= '0;
      te_q      <= 1'b0;
      sclk_q    <= 1'b0;
      sr        <= '0;
      cfg       <= CFG_RST;
      cfg_upd   <= 1'b0;
      bit_cnt   <= '0;
      len_err   <= 1'b0;
    end else begin
      te_sync   <= {te_sync[SYNC_STAGES-2:0], te};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], scan_clk};
      sin_sync  <= {sin_sync[SYNC_STAGES-2:0], scan_in};
      te_q      <= te_s;
      sclk_q    <= sclk_s;
      cfg_upd   <= commit_ok;

      // Capture outranks commit, which outranks shifting.
      if (te_rise) begin
        sr      <= cap_data;
        bit_cnt <= '0;
      end else if (te_fall) begin
        if (commit_ok) cfg <= sr;
      end else if (te_s && sclk_rise) begin
        sr <= {sr[WIDTH-2:0], sin_s};
        if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + CW'(1);
      end

      // A wrong-length sequence sets the flag even if a clear arrives together.
      if (te_fall && !commit_ok) len_err <= 1'b1;
      else if (err_clr)          len_err <= 1'b0;
    end
  end

endmodule
